// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default sizes for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_IF    = 2'd1,
    TAG_LS_LD = 2'd2,
    TAG_LS_ST = 2'd3
  } resp_tag_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_starve_ctr
// Description : Saturating fetch-starvation counter with clear and at-max flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == STARVE_CNT_W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one unified memory port between fetch and load/store,
//               data priority with fetch anti-starvation, 1-cycle tagged reads.
//               Optional perf counters: define MEM_ARB_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_store,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_req_ready,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_resp_data,
  output logic              mem_e,
  output logic              mem_s,
  output logic [ADDR_W-1:0] mem_pc,
  output logic [ADDR_W-1:0] mem_daddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_ls_grants,
  output logic [31:0]       perf_if_stalls
`endif
);

  logic              w_at_max;
  logic              w_force_if;
  logic              w_grant_ls;
  logic              w_grant_if;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] daddr_q;
  logic [DATA_W-1:0] wdata_q;
  resp_tag_t         tag_q, tag_d;

  assign w_force_if = if_req_valid & w_at_max;
  assign w_grant_ls = ~rst & ls_req_valid & ~w_force_if;
  assign w_grant_if = ~rst & if_req_valid & ~w_grant_ls;

  assign if_req_ready = w_grant_if;
  assign ls_req_ready = w_grant_ls;

  // Idle cycles keep the last fetch address so the memory sees a stable PC.
  assign mem_e     = w_grant_ls;
  assign mem_s     = w_grant_ls & ls_req_store;
  assign mem_pc    = w_grant_if ? if_req_addr  : pc_q;
  assign mem_daddr = w_grant_ls ? ls_req_addr  : daddr_q;
  assign mem_wdata = w_grant_ls ? ls_req_wdata : wdata_q;

  always_comb begin
    tag_d = TAG_NONE;
    if (w_grant_ls) begin
      tag_d = ls_req_store ? TAG_LS_ST : TAG_LS_LD;
    end else if (w_grant_if) begin
      tag_d = TAG_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= TAG_NONE;
      pc_q    <= '0;
      daddr_q <= '0;
      wdata_q <= '0;
    end else begin
      tag_q <= tag_d;
      if (w_grant_if) begin
        pc_q <= if_req_addr;
      end
      if (w_grant_ls) begin
        daddr_q <= ls_req_addr;
        wdata_q <= ls_req_wdata;
      end
    end
  end

  // Gating with rst drops a response that would otherwise surface in the reset cycle.
  assign if_resp_valid = ~rst & (tag_q == TAG_IF);
  assign ls_resp_valid = ~rst & ((tag_q == TAG_LS_LD) | (tag_q == TAG_LS_ST));
  assign if_resp_data  = mem_rdata;
  assign ls_resp_data  = mem_rdata;

  mem_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (~if_req_valid | w_grant_if),
    .inc_i    (if_req_valid & ~w_grant_if),
    .at_max_o (w_at_max)
  );

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_grants <= '0;
      perf_ls_grants <= '0;
      perf_if_stalls <= '0;
    end else begin
      if (w_grant_if) perf_if_grants <= perf_if_grants + 32'd1;
      if (w_grant_ls) perf_ls_grants <= perf_ls_grants + 32'd1;
      if (if_req_valid && !w_grant_if) perf_if_stalls <= perf_if_stalls + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the instruction-fetch stage and the load/store stage.
- Drives the memory's execute/store selects, PC and data-address inputs.
- Returns read data one cycle later with a tag identifying the requester.
- Sits between the pipeline front-end/LSU and the memory block. Fixed data priority, with anti-starvation for fetch.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, word width.
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win (range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_W  fetch byte address
- if_req_ready  out  1  fetch request accepted this cycle
- if_resp_valid  out  1  fetch data valid
- if_resp_data  out  DATA_W  fetched word
- ls_req_valid  in  1  load/store request
- ls_req_store  in  1  1 = store, 0 = load
- ls_req_addr  in  ADDR_W  data byte address
- ls_req_wdata  in  DATA_W  store data
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_resp_valid  out  1  load data valid or store acknowledge
- ls_resp_data  out  DATA_W  loaded word (don't-care for store ack)
- mem_e  out  1  memory execute select (1 = data access, 0 = fetch)
- mem_s  out  1  memory store enable
- mem_pc  out  ADDR_W  memory fetch address
- mem_daddr  out  ADDR_W  memory data address
- mem_wdata  out  DATA_W  memory store data
- mem_rdata  in  DATA_W  registered memory output, valid cycle after access

Behaviour:
- Reset (rst=1 at posedge):
  - if_resp_valid=0, ls_resp_valid=0, mem_e=0, mem_s=0.
  - mem_pc, mem_daddr, mem_wdata cleared to 0.
  - Starvation counter = 0; pending tag = NONE.
  - Responses in flight at reset are dropped, never delivered.
- Arbitration (combinational, each cycle):
  - Grant LS if ls_req_valid and not forced-fetch; else grant IF if if_req_valid.
  - Forced-fetch = if_req_valid and starve_cnt == STARVE_MAX.
  - Exactly one of if_req_ready / ls_req_ready is high per cycle; both 0 when no request or during rst.
- Memory drive (combinational from grant):
  - IF grant: mem_e=0, mem_s=0, mem_pc=if_req_addr.
  - LS grant: mem_e=1, mem_s=ls_req_store, mem_daddr=ls_req_addr, mem_wdata=ls_req_wdata.
  - No grant: mem_e=0, mem_s=0, mem_pc holds last fetch address (registered copy). The memory's harmless fetch read is discarded.
- Addresses are passed unchanged; the memory uses bits [ADDR_W-1:2]. Unaligned low bits are ignored, not trapped.
- Response pipeline:
  - Tag register records the granted requester (IF / LS_LD / LS_ST / NONE) at the posedge.
  - Next cycle: IF tag → if_resp_valid=1, if_resp_data=mem_rdata. LS_LD → ls_resp_valid=1 with data. LS_ST → ls_resp_valid=1, data don't-care.
  - Latency exactly 1 cycle after the accept cycle.
  - Throughput 1 access per cycle, back-to-back allowed.
  - No response backpressure: consumers must sink responses.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle if_req_valid=1 and IF is not granted.
  - Clears on IF grant or when if_req_valid=0.
- Boundary conditions:
  - Simultaneous requests with starve_cnt < STARVE_MAX: LS wins.
  - At STARVE_MAX: IF wins once, counter clears, LS wins next.
  - Store followed by a load to the same address next cycle returns the new data; the memory writes at the store's edge.
  - A requester dropping valid without ready is permitted and causes no side effect.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds outputs perf_if_grants, perf_ls_grants, perf_if_stalls (32-bit each):
  - Cleared on rst.
  - Incremented on IF grant, LS grant, and cycles with if_req_valid=1 denied, respectively.
  - Wrap modulo 2^32.
- When undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package mem_arb_pkg:
  - resp_tag_t enum {TAG_NONE, TAG_IF, TAG_LS_LD, TAG_LS_ST}.
  - Default ADDR_W/DATA_W constants, STARVE_MAX default.
- One sub-module, mem_arb_starve_ctr: saturating counter with clear, increment and at_max output.
- All other logic is top-level.

Test Plan:
- Reset mid-stream: LS load accepted at cycle 3, rst at cycle 4 → no ls_resp_valid at cycle 4 or later; all outputs at reset values.
- Fetch only: if_req_addr=0x0000_0010, mem[4]=0xDEAD_BEEF → if_req_ready=1 at T, mem_e=0, if_resp_valid=1 with 0xDEAD_BEEF at T+1.
- Store then load: store 0x1234_5678 to 0x0000_0020 at T, load 0x0000_0020 at T+1 → ls_resp_valid at T+1 (ack), ls_resp_data=0x1234_5678 at T+2.
- Contention, STARVE_MAX=4, both valid continuously → grants LS,LS,LS,LS,IF,LS,LS,LS,LS,IF…; if_resp_valid every 5th cycle.
- Back-to-back fetch 0x0,0x4,0x8 → three consecutive if_resp_valid cycles with mem[0..2], in order.
- MEM_ARB_PERF_CNT_EN defined, contention test over 10 cycles → perf_ls_grants=8, perf_if_grants=2, perf_if_stalls=8.
